// File: rtl/fifty_ms_clock_divider.sv
// ---------------------------------------------------------------------------
// fifty_ms_clock_divider
//
// Purpose:
//   Divides the system clock down to a slow, 50%-duty div_clock. The same
//   divider is used to sample a raw button/switch level once per div_clock
//   period, which debounces it. A tick pulse marks every div_clock rise.
//   With the default DIV_HALF and a 100 MHz clock, div_clock has a 50 ms
//   period.
//
//   div_clock is a registered output only. It never clocks a flop; the
//   debounce sample is a clock enable on the system clock.
//
// Parameters:
//   DIV_HALF  - system clocks per half period of div_clock (>= 2)
//   CNT_W     - width of the divide counter
//
// Ports:
//   clock     - in : system clock, all state updates on its rising edge
//   reset     - in : synchronous, active-high reset
//   in        - in : asynchronous raw button/switch level
//   div_clock - out: divided clock, registered, 50% duty cycle
//   tick      - out: one-cycle pulse in the cycle div_clock has just risen
//   db        - out: debounced level, in sampled once per div_clock period
// ---------------------------------------------------------------------------
module fifty_ms_clock_divider #(
    parameter int unsigned DIV_HALF = 2_500_000,
    parameter int unsigned CNT_W    = $clog2(DIV_HALF)
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic div_clock,
    output logic tick,
    output logic db
);

    // Half periods below two cycles cannot give a registered tick distinct
    // from the toggle, so reject them at elaboration.
    if (DIV_HALF < 2) begin : g_div_half_check
        $error("fifty_ms_clock_divider: DIV_HALF must be at least 2");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV_HALF - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             db_q, db_d;
    logic             s1_q, s2_q;

    logic             wrap;
    logic             rise;

    always_comb begin
        wrap   = 1'b0;
        rise   = 1'b0;
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        db_d   = db_q;

        // Wrapping on equality keeps cnt within 0..DIV_HALF-1 at all times,
        // since reset always returns it to 0.
        wrap = (cnt_q == CntLast);
        if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        div_d = div_q ^ wrap;

        // Rising edge of div_clock happens on the wrap edge while it is low.
        rise   = wrap & ~div_q;
        tick_d = rise;

        // Sample only the synchronised level, once per div_clock period.
        if (rise) begin
            db_d = s2_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
            db_q   <= 1'b0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            db_q   <= db_d;
            // Two-flop synchroniser for the asynchronous input.
            s1_q   <= in;
            s2_q   <= s1_q;
        end
    end

    assign div_clock = div_q;
    assign tick      = tick_q;
    assign db        = db_q;

endmodule

// File: tb/tb_fifty_ms_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_fifty_ms_clock_divider
//
// Drives fifty_ms_clock_divider (DIV_HALF = 3) through directed phases and a
// randomized phase, comparing every cycle against a reference model that
// works from the number of edges since reset release and the history of
// input levels seen at those edges.
// ---------------------------------------------------------------------------
module tb_fifty_ms_clock_divider;

    localparam int DH = 3;

    logic clock = 1'b0;
    logic reset;
    logic in;
    logic div_clock;
    logic tick;
    logic db;

    int tests  = 0;
    int failed = 0;

    // Reference model state.
    int   n;          // edges since reset release (0 right after a reset edge)
    logic hist[$];    // in level at edge 1, 2, ... since release
    logic exp_db;

    fifty_ms_clock_divider #(
        .DIV_HALF(DH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in       (in),
        .div_clock(div_clock),
        .tick     (tick),
        .db       (db)
    );

    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s at edge %0d: observed %b, expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s at edge %0d: observed %0d, expected %0d", tag, n, obs, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, advance the model, compare.
    task automatic cycle(input logic rst, input logic v);
        logic e_div;
        logic e_tick;
        reset = rst;
        in    = v;
        @(posedge clock);
        if (rst) begin
            n = 0;
            hist.delete();
            exp_db = 1'b0;
        end else begin
            n++;
            hist.push_back(v);
            // div_clock rises every 2*DH edges, first at edge DH; db then
            // takes the input seen two edges earlier (synchroniser depth).
            if (n % (2 * DH) == DH) begin
                exp_db = hist[n - 3];
            end
        end
        e_div  = ((n / DH) % 2) == 1;
        e_tick = (n % (2 * DH)) == DH;
        #1;
        check_bit("div_clock", div_clock, e_div);
        check_bit("tick", tick, e_tick);
        check_bit("db", db, exp_db);
        check_int("cnt", int'(dut.cnt_q), n % DH);
    endtask

    initial begin
        n      = 0;
        exp_db = 1'b0;
        reset  = 1'b1;
        in     = 1'b0;

        // Reset two cycles, release, run with in low: rises at 3 and 9.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);

        // Hold in high from release: db becomes 1 at the edge-3 sample.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
        check_bit("db_held_high", db, 1'b1);
        check_bit("div_high_before_reset", div_clock, 1'b1);

        // Reset at edge 4 while div_clock and db are high, then re-time.
        cycle(1'b1, 1'b1);
        check_bit("db_cleared_by_reset", db, 1'b0);
        check_bit("div_cleared_by_reset", div_clock, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);

        // Short pulse between sample edges must not reach db.
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= 18; i++) cycle(1'b0, (i == 3 || i == 4));
        check_bit("glitch_filtered", db, 1'b0);

        // Toggle every cycle for 60 cycles.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b0, logic'(i % 2));

        // Random input levels with occasional mid-period resets.
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 39) == 0), logic'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fifty_ms_clock_divider.md
FIFTY_MS_CLOCK_DIVIDER -- requirements
Module: fifty_ms_clock_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter DIV_HALF, default 2_500_000: system clocks per half period of div_clock; 25 ms at 100 MHz gives a 50 ms output period.
REQ-003 The block SHALL have parameter CNT_W, default $clog2(DIV_HALF): width of the divide counter.
REQ-004 The block SHALL have port clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in, input, 1 bit: asynchronous raw button/switch level.
REQ-007 The block SHALL have port div_clock, output, 1 bit: divided clock, registered, 50% duty cycle.
REQ-008 The block SHALL have port tick, output, 1 bit: one-clock pulse on each cycle in which div_clock becomes 1.
REQ-009 The block SHALL have port db, output, 1 bit: debounced level, in sampled once per div_clock period (D flip-flop stage).

Function
REQ-010 The block SHALL legalise DIV_HALF >= 2; smaller values are an elaboration error.
REQ-011 Counter cnt SHALL increment by 1 each clock while cnt < DIV_HALF-1.
REQ-012 When cnt == DIV_HALF-1, cnt SHALL wrap to 0 on the next edge, and div_clock SHALL toggle on that same edge.
REQ-013 div_clock SHALL therefore have period 2*DIV_HALF clocks, high DIV_HALF and low DIV_HALF; the first rise occurs DIV_HALF edges after reset release.
REQ-014 tick SHALL be registered and high for exactly the one cycle in which div_clock has just changed 0->1; otherwise it SHALL be 0.
REQ-015 in SHALL pass through a 2-flop synchronizer (s1, s2) before use; s1 and s2 are never bypassed.
REQ-016 On the edge at which div_clock toggles 0->1, db SHALL load s2; on all other edges db SHALL hold.
REQ-017 The sampling SHALL be a clock-enable on the system clock; div_clock SHALL NOT be used as a clock for any flop.
REQ-018 Glitches on in shorter than one div_clock period that are not present at a sample edge SHALL NOT appear on db.
REQ-019 Worst-case latency from a stable change on in to db SHALL be 2 + 2*DIV_HALF clocks.
REQ-020 The counter SHALL never exceed DIV_HALF-1, including after reset mid-count.

Reset
REQ-021 While reset is high at a clock edge, cnt SHALL become 0 and div_clock, tick, db, s1 and s2 SHALL all become 0.
REQ-022 Reset SHALL take priority over counting, toggling and sampling in the same cycle.
REQ-023 Reset asserted mid-period SHALL restart timing, so the first div_clock rise is again DIV_HALF edges after release.
REQ-024 No initial blocks SHALL be relied upon; state is defined only by reset.

Verification (DIV_HALF=3 for simulation)
REQ-025 Reset 2 cycles then release -> div_clock rises at edge 3 after release, falls at edge 6, rises at edge 9; tick is high only in the cycles after edges 3 and 9.
REQ-026 Hold in=1 from release -> db stays 0 until the edge-3 sample gives 1 (s2=1 by edge 2); db is then constant while in stays 1.
REQ-027 in pulses high for 2 cycles between sample edges -> db remains 0.
REQ-028 Assert reset at edge 4 (div_clock=1, db=1) -> next edge gives div_clock=0, db=0, tick=0, cnt=0; the next rise is 3 edges after release.
REQ-029 Toggle in every cycle for 60 cycles -> db changes only on tick cycles, and each new db equals s2 at that edge.
REQ-030 Run with default DIV_HALF=2_500_000 -> div_clock period is exactly 5_000_000 clocks and tick spacing is 5_000_000 clocks.
